// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: combinational grant search from a rotating pointer,
// with per-requester burst credits loaded from the winner's weight at burst start.
module wrr_arbiter #(
  parameter int NUM_REQ      = 8,
  parameter int PTR_WIDTH    = $clog2(NUM_REQ),
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] i_weights,
  input  logic                            i_gnt_ready,
  output logic                            o_gnt_valid,
  output logic [PTR_WIDTH-1:0]            o_gnt_idx,
  output logic [NUM_REQ-1:0]              o_gnt_onehot,
  output logic                            o_burst_last
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q;
  logic [PTR_WIDTH-1:0]    ptr_q;
  logic [WEIGHT_WIDTH-1:0] credit_q;

  logic                    found;
  logic [PTR_WIDTH-1:0]    cand;
  logic [PTR_WIDTH-1:0]    winner;
  logic [PTR_WIDTH-1:0]    next_ptr;
  logic [WEIGHT_WIDTH-1:0] weight_sel;
  logic [WEIGHT_WIDTH-1:0] weight_eff;
  logic                    continued;
  logic                    accept;

  // Index arithmetic wraps at NUM_REQ, not at 2**PTR_WIDTH, so odd sizes never visit holes.
  function automatic logic [PTR_WIDTH-1:0] wrap_add(input logic [PTR_WIDTH-1:0] base,
                                                    input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_WIDTH'(sum);
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    weight_sel   = '0;
    o_gnt_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == PTR_WIDTH'(k)) begin
        weight_sel      = i_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        o_gnt_onehot[k] = found;
      end
    end
  end

  assign weight_eff   = (weight_sel == '0) ? WEIGHT_WIDTH'(1) : weight_sel;
  assign next_ptr     = wrap_add(winner, 1);
  assign continued    = (state_q == HOLD) && (winner == ptr_q);
  assign accept       = found && i_gnt_ready;
  assign o_gnt_valid  = found;
  assign o_gnt_idx    = winner;
  // A holder that dropped its request loses the lock: any other winner starts a fresh burst.
  assign o_burst_last = found && ((!continued && weight_eff == WEIGHT_WIDTH'(1)) ||
                                  ( continued && credit_q   == WEIGHT_WIDTH'(1)));

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
    end else if (accept) begin
      if (continued) begin
        credit_q <= credit_q - WEIGHT_WIDTH'(1);
        if (credit_q == WEIGHT_WIDTH'(1)) begin
          ptr_q   <= next_ptr;
          state_q <= IDLE;
        end
      end else if (weight_eff == WEIGHT_WIDTH'(1)) begin
        ptr_q   <= next_ptr;
        state_q <= IDLE;
      end else begin
        ptr_q    <= winner;
        credit_q <= weight_eff - WEIGHT_WIDTH'(1);
        state_q  <= HOLD;
      end
    end
  end

endmodule
